// File: rtl/seven_segment_scan_if.sv
// Bus between the timer datapath and the seven-segment scan controller.
// Master drives the digit word and controls; slave returns the pin-level outputs.
interface seven_segment_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      enable;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   digits_in;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic [6:0]                seg_out;
    logic                      dp_out;
    logic [NUM_DIGITS-1:0]     an_out;
    logic [2:0]                scan_idx;

    modport master (
        output enable, load, digits_in, dp_in,
        input  seg_out, dp_out, an_out, scan_idx
    );

    modport slave (
        input  enable, load, digits_in, dp_in,
        output seg_out, dp_out, an_out, scan_idx
    );
endinterface

// File: rtl/seven_segment_scan_controller.sv
// Time-multiplexed seven-segment driver: shadows a packed hex word, scans one
// digit per prescaler period, decodes hex, blanks leading zeros and applies
// output polarity. All pin outputs are registered so anode and segment
// changes always land on the same clock edge.
module seven_segment_scan_controller #(
    parameter int NUM_DIGITS    = 4,
    parameter int DIV           = 50000,
    parameter bit ACTIVE_LOW    = 1'b1,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    seven_segment_scan_if.slave bus
);

    localparam int                    PW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]         PRESC_MAX = PW'(DIV - 1);
    localparam logic [2:0]            IDX_MAX   = 3'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF   = ACTIVE_LOW ? 7'b1111111 : 7'b0000000;
    localparam logic                  DP_OFF    = ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = ACTIVE_LOW ? {NUM_DIGITS{1'b1}}
                                                             : {NUM_DIGITS{1'b0}};

    // Hex nibble to active-high segment pattern, bit 6 = a ... bit 0 = g.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1111110;
            4'h1:    seg = 7'b0110000;
            4'h2:    seg = 7'b1101101;
            4'h3:    seg = 7'b1111001;
            4'h4:    seg = 7'b0110011;
            4'h5:    seg = 7'b1011011;
            4'h6:    seg = 7'b1011111;
            4'h7:    seg = 7'b1110000;
            4'h8:    seg = 7'b1111111;
            4'h9:    seg = 7'b1111011;
            4'hA:    seg = 7'b1110111;
            4'hB:    seg = 7'b0011111;
            4'hC:    seg = 7'b1001110;
            4'hD:    seg = 7'b0111101;
            4'hE:    seg = 7'b1001111;
            4'hF:    seg = 7'b1000111;
            default: seg = 7'b0000000;
        endcase
        return seg;
    endfunction

    logic [PW-1:0]           presc_q, presc_d;
    logic [2:0]              idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   dpsh_q, dpsh_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_out_q, dp_out_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [2:0]              scan_idx_q, scan_idx_d;

    logic [3:0]              nib_s;
    logic                    dp_sel_s;
    logic                    blank_s;
    logic                    upper_zero_s;
    logic [NUM_DIGITS-1:0]   an_act_s;
    logic [6:0]              seg_act_s;
    logic                    dp_act_s;

    // Prescaler and digit index advance; both freeze while scanning is disabled.
    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        if (bus.enable) begin
            if (presc_q == PRESC_MAX) begin
                presc_d = {PW{1'b0}};
                idx_d   = (idx_q == IDX_MAX) ? 3'd0 : idx_q + 3'd1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end else begin
            presc_d = presc_q;
            idx_d   = idx_q;
        end
    end

    // Shadow capture of the digit word and decimal points on load.
    always_comb begin
        if (bus.load) begin
            digits_d = bus.digits_in;
            dpsh_d   = bus.dp_in;
        end else begin
            digits_d = digits_q;
            dpsh_d   = dpsh_q;
        end
    end

    // Select the active digit and decide blanking, scanning from the top digit
    // down so upper_zero_s tracks "this digit and all above it are zero".
    always_comb begin
        nib_s        = 4'd0;
        dp_sel_s     = 1'b0;
        blank_s      = 1'b0;
        upper_zero_s = 1'b1;
        an_act_s     = {NUM_DIGITS{1'b0}};
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            upper_zero_s = upper_zero_s & (digits_q[4*k +: 4] == 4'd0);
            an_act_s[k]  = (idx_q == 3'(k));
            nib_s        = nib_s | ({4{an_act_s[k]}} & digits_q[4*k +: 4]);
            dp_sel_s     = dp_sel_s | (an_act_s[k] & dpsh_q[k]);
            blank_s      = blank_s | (an_act_s[k] & BLANK_LEADING & (k != 0) & upper_zero_s);
        end
    end

    // Next pin values: dark when disabled, polarity applied last.
    always_comb begin
        if (bus.enable) begin
            seg_act_s = blank_s ? 7'b0000000 : hex_to_seg(nib_s);
            dp_act_s  = dp_sel_s;
            an_d      = an_act_s ^ AN_OFF;
        end else begin
            seg_act_s = 7'b0000000;
            dp_act_s  = 1'b0;
            an_d      = AN_OFF;
        end
        seg_d      = seg_act_s ^ SEG_OFF;
        dp_out_d   = dp_act_s ^ DP_OFF;
        scan_idx_d = idx_q;
    end

    // Scan state and shadow registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q  <= {PW{1'b0}};
            idx_q    <= 3'd0;
            digits_q <= {(4*NUM_DIGITS){1'b0}};
            dpsh_q   <= {NUM_DIGITS{1'b0}};
        end else begin
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            digits_q <= digits_d;
            dpsh_q   <= dpsh_d;
        end
    end

    // Registered pin outputs; reset forces every output to its inactive level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_q      <= SEG_OFF;
            dp_out_q   <= DP_OFF;
            an_q       <= AN_OFF;
            scan_idx_q <= 3'd0;
        end else begin
            seg_q      <= seg_d;
            dp_out_q   <= dp_out_d;
            an_q       <= an_d;
            scan_idx_q <= scan_idx_d;
        end
    end

    assign bus.seg_out  = seg_q;
    assign bus.dp_out   = dp_out_q;
    assign bus.an_out   = an_q;
    assign bus.scan_idx = scan_idx_q;

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Bench for seven_segment_scan_controller: three instances share stimulus
// (A: DIV=4 active-low blanking, B: DIV=4 active-low no blanking,
// C: DIV=1 active-high blanking). A cycle model pushes expected outputs into
// a queue before each edge; they are popped and compared after the edge.
// Directed constant checks cover the key points of each scenario.
module tb_seven_segment_scan_controller;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic [2:0] idx;
    } exp_t;

    logic        clk;
    logic        rst_s;
    logic        en_s;
    logic        load_s;
    logic [15:0] dig_s;
    logic [3:0]  dpin_s;

    int n_cmp  = 0;
    int n_fail = 0;

    exp_t exp_q[$];

    int   divs [3] = '{4, 4, 1};
    bit   als  [3] = '{1'b1, 1'b1, 1'b0};
    bit   bls  [3] = '{1'b1, 1'b0, 1'b1};
    int          m_presc [3];
    int          m_idx   [3];
    logic [15:0] m_dig   [3];
    logic [3:0]  m_dp    [3];

    logic [6:0] dec_tab [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    logic [6:0] seg_o [3];
    logic       dp_o  [3];
    logic [3:0] an_o  [3];
    logic [2:0] idx_o [3];

    seven_segment_scan_if #(.NUM_DIGITS(4)) if_a ();
    seven_segment_scan_if #(.NUM_DIGITS(4)) if_b ();
    seven_segment_scan_if #(.NUM_DIGITS(4)) if_c ();

    assign if_a.enable = en_s;   assign if_a.load = load_s;
    assign if_a.digits_in = dig_s; assign if_a.dp_in = dpin_s;
    assign if_b.enable = en_s;   assign if_b.load = load_s;
    assign if_b.digits_in = dig_s; assign if_b.dp_in = dpin_s;
    assign if_c.enable = en_s;   assign if_c.load = load_s;
    assign if_c.digits_in = dig_s; assign if_c.dp_in = dpin_s;

    assign seg_o[0] = if_a.seg_out; assign dp_o[0] = if_a.dp_out;
    assign an_o[0]  = if_a.an_out;  assign idx_o[0] = if_a.scan_idx;
    assign seg_o[1] = if_b.seg_out; assign dp_o[1] = if_b.dp_out;
    assign an_o[1]  = if_b.an_out;  assign idx_o[1] = if_b.scan_idx;
    assign seg_o[2] = if_c.seg_out; assign dp_o[2] = if_c.dp_out;
    assign an_o[2]  = if_c.an_out;  assign idx_o[2] = if_c.scan_idx;

    seven_segment_scan_controller #(.NUM_DIGITS(4), .DIV(4), .ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b1))
        dut_a (.clk(clk), .reset(rst_s), .bus(if_a));
    seven_segment_scan_controller #(.NUM_DIGITS(4), .DIV(4), .ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b0))
        dut_b (.clk(clk), .reset(rst_s), .bus(if_b));
    seven_segment_scan_controller #(.NUM_DIGITS(4), .DIV(1), .ACTIVE_LOW(1'b0), .BLANK_LEADING(1'b1))
        dut_c (.clk(clk), .reset(rst_s), .bus(if_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic exp_t model_out(int d);
        exp_t e;
        logic [3:0] nib;
        bit blank;
        if (en_s) begin
            nib   = 4'((m_dig[d] >> (4 * m_idx[d])) & 16'h000F);
            blank = bls[d] && (m_idx[d] > 0) && ((m_dig[d] >> (4 * m_idx[d])) == 16'h0000);
            e.seg = blank ? 7'b0000000 : dec_tab[nib];
            e.dp  = m_dp[d][m_idx[d]];
            e.an  = 4'b0001 << m_idx[d];
        end else begin
            e.seg = 7'b0000000;
            e.dp  = 1'b0;
            e.an  = 4'b0000;
        end
        if (als[d]) begin
            e.seg = ~e.seg;
            e.dp  = ~e.dp;
            e.an  = ~e.an;
        end
        e.idx = 3'(m_idx[d]);
        return e;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_presc[d] = 0;
            m_idx[d]   = 0;
            m_dig[d]   = 16'h0000;
            m_dp[d]    = 4'b0000;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("%s_d%0d_seg", tag, d), {1'b0, seg_o[d]}, als[d] ? 8'h7F : 8'h00);
            check($sformatf("%s_d%0d_dp", tag, d), {7'b0, dp_o[d]}, als[d] ? 8'h01 : 8'h00);
            check($sformatf("%s_d%0d_an", tag, d), {4'b0, an_o[d]}, als[d] ? 8'h0F : 8'h00);
            check($sformatf("%s_d%0d_idx", tag, d), {5'b0, idx_o[d]}, 8'h00);
        end
    endtask

    // One clock: push model expectations, advance model, compare after the edge.
    task automatic tick();
        exp_t e;
        for (int d = 0; d < 3; d++) exp_q.push_back(model_out(d));
        for (int d = 0; d < 3; d++) begin
            if (load_s) begin
                m_dig[d] = dig_s;
                m_dp[d]  = dpin_s;
            end
            if (en_s) begin
                if (m_presc[d] == divs[d] - 1) begin
                    m_presc[d] = 0;
                    m_idx[d]   = (m_idx[d] == 3) ? 0 : m_idx[d] + 1;
                end else begin
                    m_presc[d] = m_presc[d] + 1;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            e = exp_q.pop_front();
            check($sformatf("sb_d%0d_seg", d), {1'b0, seg_o[d]}, {1'b0, e.seg});
            check($sformatf("sb_d%0d_dp", d), {7'b0, dp_o[d]}, {7'b0, e.dp});
            check($sformatf("sb_d%0d_an", d), {4'b0, an_o[d]}, {4'b0, e.an});
            check($sformatf("sb_d%0d_idx", d), {5'b0, idx_o[d]}, {5'b0, e.idx});
        end
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Reset raised between edges; outputs must go inactive before any clock.
    task automatic do_reset(input string tag);
        en_s   = 1'b0;
        load_s = 1'b0;
        rst_s  = 1'b1;
        #3;
        check_reset_vals(tag);
        @(posedge clk);
        #1;
        rst_s = 1'b0;
        model_reset();
    endtask

    initial begin
        rst_s  = 1'b1;
        en_s   = 1'b0;
        load_s = 1'b0;
        dig_s  = 16'h0000;
        dpin_s = 4'b0000;
        model_reset();
        @(posedge clk);
        #1;
        check_reset_vals("rst_init");
        rst_s = 1'b0;

        // Scan order and timing with 0x1234
        dig_s = 16'h1234; dpin_s = 4'b0000; load_s = 1'b1; en_s = 1'b1;
        tick();
        load_s = 1'b0;
        tick_n(2);
        check("p1_e3_an", {4'b0, an_o[0]}, 8'b0000_1110);
        check("p1_e3_seg", {1'b0, seg_o[0]}, 8'b0100_1100);
        tick_n(2);
        check("p1_e5_an", {4'b0, an_o[0]}, 8'b0000_1101);
        tick_n(9);
        check("p1_e14_an", {4'b0, an_o[0]}, 8'b0000_0111);
        check("p1_e14_seg", {1'b0, seg_o[0]}, 8'b0100_1111);
        tick_n(3);
        check("p1_e17_an", {4'b0, an_o[0]}, 8'b0000_1110);

        // Leading-zero blanking with 0x0050 (A blanks, B does not)
        do_reset("rst_mid1");
        dig_s = 16'h0050; load_s = 1'b1; en_s = 1'b1;
        tick();
        load_s = 1'b0;
        tick_n(2);
        check("p2_e3_seg0", {1'b0, seg_o[0]}, 8'b0000_0001);
        tick_n(3);
        check("p2_e6_seg1", {1'b0, seg_o[0]}, 8'b0010_0100);
        tick_n(4);
        check("p2_e10_an", {4'b0, an_o[0]}, 8'b0000_1011);
        check("p2_e10_a_seg2", {1'b0, seg_o[0]}, 8'b0111_1111);
        check("p2_e10_b_seg2", {1'b0, seg_o[1]}, 8'b0000_0001);
        tick_n(4);
        check("p2_e14_a_seg3", {1'b0, seg_o[0]}, 8'b0111_1111);
        check("p2_e14_b_seg3", {1'b0, seg_o[1]}, 8'b0000_0001);
        check("p2_e14_an", {4'b0, an_o[0]}, 8'b0000_0111);

        // Freeze at idx=2 mid-slot, resume with held prescaler
        do_reset("rst_mid2");
        dig_s = 16'h1234; dpin_s = 4'b0000; load_s = 1'b1; en_s = 1'b1;
        tick();
        load_s = 1'b0;
        tick_n(9);
        check("p3_e10_an", {4'b0, an_o[0]}, 8'b0000_1011);
        en_s = 1'b0;
        tick();
        check("p3_off_an", {4'b0, an_o[0]}, 8'b0000_1111);
        check("p3_off_seg", {1'b0, seg_o[0]}, 8'b0111_1111);
        check("p3_off_dp", {7'b0, dp_o[0]}, 8'h01);
        check("p3_off_idx", {5'b0, idx_o[0]}, 8'h02);
        tick_n(9);
        check("p3_e20_an", {4'b0, an_o[0]}, 8'b0000_1111);
        en_s = 1'b1;
        tick();
        check("p3_e21_an", {4'b0, an_o[0]}, 8'b0000_1011);
        tick();
        check("p3_e22_an", {4'b0, an_o[0]}, 8'b0000_1011);
        tick();
        check("p3_e23_an", {4'b0, an_o[0]}, 8'b0000_0111);

        // Load collides with prescaler wrap; dp on digit 2 only
        tick_n(2);
        dig_s = 16'h5678; dpin_s = 4'b0100; load_s = 1'b1;
        tick();
        check("p4_e26_an", {4'b0, an_o[0]}, 8'b0000_0111);
        check("p4_e26_seg", {1'b0, seg_o[0]}, 8'b0100_1111);
        load_s = 1'b0;
        tick();
        check("p4_e27_an", {4'b0, an_o[0]}, 8'b0000_1110);
        check("p4_e27_seg", {1'b0, seg_o[0]}, 8'b0000_0000);
        check("p4_e27_dp", {7'b0, dp_o[0]}, 8'h01);
        tick_n(5);
        check("p4_e32_an", {4'b0, an_o[0]}, 8'b0000_1101);
        check("p4_e32_dp", {7'b0, dp_o[0]}, 8'h01);
        tick_n(4);
        check("p4_e36_an", {4'b0, an_o[0]}, 8'b0000_1011);
        check("p4_e36_dp", {7'b0, dp_o[0]}, 8'h00);
        check("p4_e36_seg", {1'b0, seg_o[0]}, 8'b0010_0000);

        // Active-high polarity, DIV=1, hex decode of 0xABCD on instance C
        do_reset("rst_mid3");
        dig_s = 16'hABCD; dpin_s = 4'b0000; load_s = 1'b1; en_s = 1'b1;
        tick();
        check("p5_e1_an", {4'b0, an_o[2]}, 8'b0000_0001);
        check("p5_e1_seg", {1'b0, seg_o[2]}, 8'b0111_1110);
        load_s = 1'b0;
        tick_n(4);
        check("p5_d_an", {4'b0, an_o[2]}, 8'b0000_0001);
        check("p5_d_seg", {1'b0, seg_o[2]}, 8'b0011_1101);
        tick();
        check("p5_c_an", {4'b0, an_o[2]}, 8'b0000_0010);
        check("p5_c_seg", {1'b0, seg_o[2]}, 8'b0100_1110);
        tick();
        check("p5_b_an", {4'b0, an_o[2]}, 8'b0000_0100);
        check("p5_b_seg", {1'b0, seg_o[2]}, 8'b0001_1111);
        tick();
        check("p5_a_an", {4'b0, an_o[2]}, 8'b0000_1000);
        check("p5_a_seg", {1'b0, seg_o[2]}, 8'b0111_0111);
        tick_n(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
